us_tick_timer: RTL

//   Programmable microsecond timer fed by the clock divider's 1 MHz output.

---
 rtl/us_tick_timer.sv | 114 +++++++++++
 1 files changed

// File: rtl/us_tick_timer.sv
// Microsecond timer: edge-detects the 1 MHz divider output as data in the 16 MHz domain
// and counts ticks down from a programmed period, in one-shot or auto-reload mode.
module us_tick_timer #(
    parameter int unsigned PWIDTH  = 16,
    parameter int unsigned ECWIDTH = 8
) (
    input  logic               clk16MHz,
    input  logic               reset,
    input  logic               clk1MHz,
    input  logic               start,
    input  logic               stop,
    input  logic               periodic,
    input  logic [PWIDTH-1:0]  period,
    output logic               tick_1us,
    output logic               busy,
    output logic [PWIDTH-1:0]  count,
    output logic               expire,
    output logic [ECWIDTH-1:0] expire_cnt
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e               state_q, state_d;
    logic                 prev_q;
    logic                 tick_q;
    logic [PWIDTH-1:0]    count_q, count_d;
    logic [PWIDTH-1:0]    period_q, period_d;
    logic                 periodic_q, periodic_d;
    logic                 expire_q, expire_d;
    logic [ECWIDTH-1:0]   ecnt_q, ecnt_d;
    logic                 tick;
    logic                 start_ok;

    // Same-cycle tick so the count moves together with the registered tick_1us pulse.
    assign tick     = clk1MHz & ~prev_q;
    assign start_ok = start && (period != '0);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        period_d   = period_q;
        periodic_d = periodic_q;
        expire_d   = 1'b0;
        ecnt_d     = ecnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok && !stop) begin
                    state_d    = StRun;
                    count_d    = period;
                    period_d   = period;
                    periodic_d = periodic;
                    ecnt_d     = '0;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                    count_d = '0;
                end else if (start_ok) begin
                    count_d    = period;
                    period_d   = period;
                    periodic_d = periodic;
                    ecnt_d     = '0;
                end else if (tick) begin
                    if (count_q > PWIDTH'(1)) begin
                        count_d = count_q - PWIDTH'(1);
                    end else begin
                        expire_d = 1'b1;
                        if (ecnt_q != '1) begin
                            ecnt_d = ecnt_q + ECWIDTH'(1);
                        end
                        if (periodic_q) begin
                            count_d = period_q;
                        end else begin
                            count_d = '0;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // prev resets high so a clk1MHz already high at reset release yields no tick.
    always_ff @(posedge clk16MHz) begin
        if (reset) begin
            state_q    <= StIdle;
            prev_q     <= 1'b1;
            tick_q     <= 1'b0;
            count_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            expire_q   <= 1'b0;
            ecnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= clk1MHz;
            tick_q     <= tick;
            count_q    <= count_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
            expire_q   <= expire_d;
            ecnt_q     <= ecnt_d;
        end
    end

    assign tick_1us   = tick_q;
    assign busy       = (state_q == StRun);
    assign count      = count_q;
    assign expire     = expire_q;
    assign expire_cnt = ecnt_q;

endmodule
